// File: rtl/button_press_decoder_pkg.sv
// Shared definitions for the pushbutton decoder: FSM encoding and
// millisecond-to-cycle conversion helpers.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_t;

    // Cycle count for a time interval, never less than one cycle.
    function automatic int ms_to_cycles(input int clock_speed, input int ms);
        int c;
        c = clock_speed / 1000 * ms;
        return (c < 1) ? 1 : c;
    endfunction

    // Repeat interval variant: zero is meaningful (repeat disabled).
    function automatic int ms_to_cycles_rep(input int clock_speed, input int ms);
        int c;
        c = clock_speed / 1000 * ms;
        return (c < 0) ? 0 : c;
    endfunction

endpackage

// File: rtl/button_sync_debounce.sv
// Two-flop synchroniser plus stability-counter debouncer for an
// active-low pushbutton pin. Output is 1 while the button is held.
module button_sync_debounce #(
    parameter int DEB_CYC = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button_n,
    output logic pressed
);

    localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_pressed;
    logic [DW-1:0] r_cnt;
    logic          w_sync;

    // Synchroniser resets to "released" so a held pin looks like a fresh press.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= button_n;
            r_s2 <= r_s1;
        end
    end

    assign w_sync = ~r_s2;

    // Count cycles of disagreement; toggle only after DEB_CYC in a row.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_pressed <= 1'b0;
        end else if (w_sync == r_pressed) begin
            r_cnt <= '0;
        end else if (r_cnt == DEB_LAST) begin
            r_pressed <= ~r_pressed;
            r_cnt     <= '0;
        end else begin
            r_cnt <= r_cnt + DW'(1);
        end
    end

    assign pressed = r_pressed;

endmodule

// File: rtl/button_press_decoder.sv
// Pushbutton decoder: debounced level plus short / long / auto-repeat
// press events as registered single-cycle pulses.
module button_press_decoder
    import button_pkg::*;
#(
    parameter int clock_speed = 25000000,
    parameter int debounce_ms = 20,
    parameter int long_ms     = 1000,
    parameter int repeat_ms   = 200
) (
    input  logic clock,
    input  logic reset_n,
    input  logic button_n,
    output logic pressed,
    output logic press_short,
    output logic press_long,
    output logic press_repeat,
    output logic held_long
);

    localparam int DEB_CYC  = ms_to_cycles(clock_speed, debounce_ms);
    localparam int LONG_CYC = ms_to_cycles(clock_speed, long_ms);
    localparam int REP_CYC  = ms_to_cycles_rep(clock_speed, repeat_ms);

    localparam int HW = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
    localparam int RW = (REP_CYC > 1) ? $clog2(REP_CYC) : 1;

    // The hold counter starts at 0 on the first PRESSED cycle, so the long
    // threshold is hit on the edge that would take it to LONG_CYC-1.
    localparam bit            LONG_IMM  = (LONG_CYC < 2);
    localparam logic [HW-1:0] LONG_PRE  = HW'((LONG_CYC >= 2) ? LONG_CYC - 2 : 0);
    localparam bit            REP_EN    = (REP_CYC > 0);
    localparam logic [RW-1:0] REP_LAST  = RW'((REP_CYC > 0) ? REP_CYC - 1 : 0);

    logic          w_pressed;
    btn_state_t    r_state;
    btn_state_t    w_state_nxt;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic [RW-1:0] r_rep;
    logic [RW-1:0] w_rep_nxt;
    logic          r_short;
    logic          r_long;
    logic          r_repeat;
    logic          r_held_long;
    logic          w_short_nxt;
    logic          w_long_nxt;
    logic          w_repeat_nxt;
    logic          w_held_nxt;
    logic          w_long_hit;

    button_sync_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_sync_debounce (
        .clock    (clock),
        .reset_n  (reset_n),
        .button_n (button_n),
        .pressed  (w_pressed)
    );

    assign w_long_hit = LONG_IMM || (r_hold == LONG_PRE);

    // Next-state and next-output logic; long threshold beats release.
    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold;
        w_rep_nxt    = r_rep;
        w_short_nxt  = 1'b0;
        w_long_nxt   = 1'b0;
        w_repeat_nxt = 1'b0;
        w_held_nxt   = r_held_long;
        case (r_state)
            IDLE: begin
                w_hold_nxt = '0;
                w_rep_nxt  = '0;
                w_held_nxt = 1'b0;
                if (w_pressed) w_state_nxt = PRESSED;
            end
            PRESSED: begin
                if (w_long_hit) begin
                    w_long_nxt  = 1'b1;
                    w_held_nxt  = 1'b1;
                    w_rep_nxt   = '0;
                    w_state_nxt = HELD;
                end else if (!w_pressed) begin
                    w_short_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_hold_nxt = r_hold + HW'(1);
                end
            end
            HELD: begin
                if (!w_pressed) begin
                    w_held_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end else if (REP_EN) begin
                    if (r_rep == REP_LAST) begin
                        w_repeat_nxt = 1'b1;
                        w_rep_nxt    = '0;
                    end else begin
                        w_rep_nxt = r_rep + RW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_held_nxt  = 1'b0;
            end
        endcase
    end

    // State, counters and registered pulse outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_rep       <= '0;
            r_short     <= 1'b0;
            r_long      <= 1'b0;
            r_repeat    <= 1'b0;
            r_held_long <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_rep       <= w_rep_nxt;
            r_short     <= w_short_nxt;
            r_long      <= w_long_nxt;
            r_repeat    <= w_repeat_nxt;
            r_held_long <= w_held_nxt;
        end
    end

    assign pressed      = w_pressed;
    assign press_short  = r_short;
    assign press_long   = r_long;
    assign press_repeat = r_repeat;
    assign held_long    = r_held_long;

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed bench for button_press_decoder with DEB_CYC=4, LONG_CYC=20,
// REP_CYC=5. Each scenario counts edges c from the edge before its first
// stimulus; a pin change made after edge k shows on pressed after edge k+6.
// Observed vector is {pressed, press_short, press_long, press_repeat, held_long}.
module tb_button_press_decoder;

    logic clock;
    logic reset_n;
    logic button_n;
    logic pressed;
    logic press_short;
    logic press_long;
    logic press_repeat;
    logic held_long;

    int n_vec;
    int n_err;
    logic [4:0] obs;
    logic [4:0] exp_v;

    button_press_decoder #(
        .clock_speed (1000),
        .debounce_ms (4),
        .long_ms     (20),
        .repeat_ms   (5)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .button_n     (button_n),
        .pressed      (pressed),
        .press_short  (press_short),
        .press_long   (press_long),
        .press_repeat (press_repeat),
        .held_long    (held_long)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Held pin through reset: outputs zero, then a fresh press 6 edges on.
    task automatic test_reset();
        reset_n  = 1'b0;
        button_n = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            obs = {pressed, press_short, press_long, press_repeat, held_long};
            n_vec++;
            if (obs !== 5'b00000) begin
                n_err++;
                $display("FAIL reset_hold c=%0d got=%b exp=00000", c, obs);
            end
        end
        reset_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 8) button_n = 1'b1;
            obs   = {pressed, press_short, press_long, press_repeat, held_long};
            exp_v = {(c >= 6 && c < 14), (c == 15), 1'b0, 1'b0, 1'b0};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL reset_release c=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
    endtask

    // 10-cycle press gives one press_short after the debounced release.
    task automatic test_short();
        button_n = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            step();
            if (c == 10) button_n = 1'b1;
            obs   = {pressed, press_short, press_long, press_repeat, held_long};
            exp_v = {(c >= 6 && c < 16), (c == 17), 1'b0, 1'b0, 1'b0};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL short c=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
    endtask

    // Three 3-cycle lows separated by 1-cycle highs never pass the debouncer.
    task automatic test_glitch();
        button_n = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            step();
            // value for edge c+1
            button_n = !((c + 1 <= 3) || (c + 1 >= 5 && c + 1 <= 7) || (c + 1 >= 9 && c + 1 <= 11));
            obs = {pressed, press_short, press_long, press_repeat, held_long};
            n_vec++;
            if (obs !== 5'b00000) begin
                n_err++;
                $display("FAIL glitch c=%0d got=%b exp=00000", c, obs);
            end
        end
        button_n = 1'b1;
    endtask

    // Exactly DEB_CYC cycles low is the shortest accepted press.
    task automatic test_min_press();
        button_n = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 4) button_n = 1'b1;
            obs   = {pressed, press_short, press_long, press_repeat, held_long};
            exp_v = {(c >= 6 && c < 10), (c == 11), 1'b0, 1'b0, 1'b0};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL min_press c=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
    endtask

    // 40-cycle hold: long at +20 from pressed, repeats every 5, no short.
    task automatic test_long();
        button_n = 1'b0;
        for (int c = 1; c <= 55; c++) begin
            step();
            if (c == 40) button_n = 1'b1;
            obs   = {pressed, press_short, press_long, press_repeat, held_long};
            exp_v = {(c >= 6 && c < 46), 1'b0, (c == 26),
                     (c == 31 || c == 36 || c == 41 || c == 46),
                     (c >= 26 && c < 47)};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL long c=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
    endtask

    // pressed falls on the same edge the long threshold is hit: long only.
    task automatic test_coincide();
        button_n = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            step();
            if (c == 20) button_n = 1'b1;
            obs   = {pressed, press_short, press_long, press_repeat, held_long};
            exp_v = {(c >= 6 && c < 26), 1'b0, (c == 26), 1'b0, (c == 26)};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL coincide c=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
    endtask

    // One-cycle reset while HELD discards the press; held pin re-presses.
    task automatic test_reset_held();
        button_n = 1'b0;
        for (int c = 1; c <= 75; c++) begin
            reset_n  = (c != 31);
            button_n = (c > 60);
            step();
            obs = {pressed, press_short, press_long, press_repeat, held_long};
            if (c < 31)
                exp_v = {(c >= 6), 1'b0, (c == 26), 1'b0, (c >= 26)};
            else
                exp_v = {(c >= 37 && c < 66), 1'b0, (c == 57), (c == 62), (c >= 57 && c < 67)};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL reset_held c=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n  = 1'b0;
        button_n = 1'b1;
        test_reset();
        test_short();
        test_glitch();
        test_min_press();
        test_long();
        test_coincide();
        test_reset_held();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
